// File: rtl/iter_alu_pkg.sv
// Shared definitions for the iterative ALU.
// Holds the opcode encoding and the control FSM state encoding used by
// iter_alu (top) and iter_alu_mdu (iterative multiply/divide datapath).
package iter_alu_pkg;

  typedef enum logic [3:0] {
    OpAdd   = 4'b0000,
    OpAnd   = 4'b0001,
    OpOr    = 4'b0010,
    OpXor   = 4'b0011,
    OpSub   = 4'b0100,
    OpNor   = 4'b0101,
    OpSltu  = 4'b0110,
    OpPassa = 4'b0111,
    OpSll   = 4'b1000,
    OpSrl   = 4'b1001,
    OpSra   = 4'b1010,
    OpSlt   = 4'b1011,
    OpMult  = 4'b1100,
    OpMultu = 4'b1101,
    OpDiv   = 4'b1110,
    OpDivu  = 4'b1111
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StDiv  = 2'b10,
    StHold = 2'b11
  } state_e;

endpackage

// File: rtl/iter_alu_mdu.sv
// Iterative multiply/divide datapath: radix-2 shift-add multiply and restoring divide,
// one iteration per cycle, WIDTH iterations. Operates on magnitudes; signs are applied to
// the final step's output so done_o and lo_o/hi_o are valid in the same (last) cycle.
// Divider logic only exists when ITER_ALU_DIV_EN is defined.
// Ports: clk, rst_n (async active-low); start_i loads operands; abort_i cancels;
//        is_div_i (divider builds only) selects divide; is_signed_i selects signed;
//        a_i/b_i operands; done_o high in the last iteration cycle; lo_o/hi_o results.
module iter_alu_mdu
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
`ifdef ITER_ALU_DIV_EN
  input  logic             is_div_i,
`endif
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic               busy_q, busy_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  // Multiply: {partial sum, multiplier}; divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               neg_lo_q, neg_lo_d;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = is_signed_i & a_i[WIDTH-1];
  assign b_neg = is_signed_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign done_o  = busy_q & (cnt_q == SHW'(WIDTH - 1));
  assign prod    = neg_lo_q ? -step : step;

`ifdef ITER_ALU_DIV_EN
  logic           div_q, div_d;
  logic           neg_hi_q, neg_hi_d;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  assign rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial  = rem_sh - {1'b0, opnd_q};

  always_comb begin
    if (!div_q) begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (trial[WIDTH]) begin
      // Trial subtraction went negative: restore, quotient bit 0.
      step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_comb begin
    if (div_q) begin
      lo_o = neg_lo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
      hi_o = neg_hi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
    end else begin
      lo_o = prod[WIDTH-1:0];
      hi_o = prod[2*WIDTH-1:WIDTH];
    end
  end
`else
  assign step = {mul_sum, acc_q[WIDTH-1:1]};
  assign lo_o = prod[WIDTH-1:0];
  assign hi_o = prod[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
`ifdef ITER_ALU_DIV_EN
    div_d    = div_q;
    neg_hi_d = neg_hi_q;
`endif
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d   = 1'b1;
      cnt_d    = '0;
      acc_d    = {{WIDTH{1'b0}}, a_mag};
      opnd_d   = b_mag;
      neg_lo_d = a_neg ^ b_neg;
`ifdef ITER_ALU_DIV_EN
      div_d    = is_div_i;
      // Remainder takes the sign of the dividend.
      neg_hi_d = is_div_i ? a_neg : (a_neg ^ b_neg);
`endif
    end else if (busy_q) begin
      acc_d = step;
      cnt_d = cnt_q + SHW'(1);
      if (done_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
`ifdef ITER_ALU_DIV_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
`ifdef ITER_ALU_DIV_EN
      div_q    <= div_d;
      neg_hi_q <= neg_hi_d;
`endif
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU top: control FSM, single-cycle operations and registered output.
// MULT/MULTU (and DIV/DIVU when ITER_ALU_DIV_EN is defined) run in iter_alu_mdu.
// Without ITER_ALU_DIV_EN, DIV/DIVU finish in one cycle with result 0, hi 0, dz 1.
// Ports: clk, rst_n (async active-low); in_valid/in_ready request handshake;
//        op/a/b/shamt operation; flush synchronous abort; out_valid/out_ready result
//        handshake; result/hi outputs; zero/sf/of/cf/dz flags; busy while iterating.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             sf,
  output logic             of,
  output logic             cf,
  output logic             dz,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, hi_q, hi_d;
  logic             zero_q, zero_d, sf_q, sf_d, of_q, of_d, cf_q, cf_d, dz_q, dz_d;
  logic             div_of_q, div_of_d;

  logic             accept, is_iter, mdu_start, mdu_done;
  logic [WIDTH-1:0] mdu_lo, mdu_hi;
  logic [WIDTH:0]   add_w, sub_w;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_cf, alu_of, alu_dz;

  assign in_ready = (state_q == StIdle) | ((state_q == StHold) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign busy     = (state_q == StMul) | (state_q == StDiv);

`ifdef ITER_ALU_DIV_EN
  // Divide by zero is resolved without iterating.
  assign is_iter = op[3] & op[2] & (~op[1] | (b != '0));
`else
  assign is_iter = op[3] & op[2] & ~op[1];
`endif

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_dz  = 1'b0;
    unique case (op_e'(op))
      OpAdd: begin
        alu_res = add_w[WIDTH-1:0];
        alu_cf  = add_w[WIDTH];
        alu_of  = (a[WIDTH-1] == b[WIDTH-1]) & (add_w[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_cf  = sub_w[WIDTH];
        alu_of  = (a[WIDTH-1] != b[WIDTH-1]) & (sub_w[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd:   alu_res = a & b;
      OpOr:    alu_res = a | b;
      OpXor:   alu_res = a ^ b;
      OpNor:   alu_res = ~(a | b);
      OpSltu:  alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OpPassa: alu_res = a;
      OpSll:   alu_res = b << shamt;
      OpSrl:   alu_res = b >> shamt;
      OpSra:   alu_res = $signed(b) >>> shamt;
      OpSlt:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpMult, OpMultu: alu_res = '0;
      OpDiv, OpDivu: begin
`ifdef ITER_ALU_DIV_EN
        alu_res = '1;
        alu_hi  = a;
`endif
        alu_dz  = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    hi_d        = hi_q;
    zero_d      = zero_q;
    sf_d        = sf_q;
    of_d        = of_q;
    cf_d        = cf_q;
    dz_d        = dz_q;
    div_of_d    = div_of_q;
    mdu_start   = 1'b0;
    if (flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StHold: begin
          if ((state_q == StHold) && out_ready) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
          end
          if (accept) begin
            if (is_iter) begin
              mdu_start   = 1'b1;
              state_d     = op[1] ? StDiv : StMul;
              out_valid_d = 1'b0;
              div_of_d    = ~op[0] & (a == MinVal) & (b == '1);
            end else begin
              state_d     = StHold;
              out_valid_d = 1'b1;
              result_d    = alu_res;
              hi_d        = alu_hi;
              zero_d      = (alu_res == '0);
              sf_d        = alu_res[WIDTH-1];
              of_d        = alu_of;
              cf_d        = alu_cf;
              dz_d        = alu_dz;
            end
          end
        end
        StMul, StDiv: begin
          if (mdu_done) begin
            state_d     = StHold;
            out_valid_d = 1'b1;
            result_d    = mdu_lo;
            hi_d        = mdu_hi;
            sf_d        = mdu_lo[WIDTH-1];
            cf_d        = 1'b0;
            dz_d        = 1'b0;
            if (state_q == StMul) begin
              zero_d = ((mdu_lo | mdu_hi) == '0);
              of_d   = 1'b0;
            end else begin
              zero_d = (mdu_lo == '0);
              of_d   = div_of_q;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
      cf_q        <= 1'b0;
      dz_q        <= 1'b0;
      div_of_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      hi_q        <= hi_d;
      zero_q      <= zero_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
      cf_q        <= cf_d;
      dz_q        <= dz_d;
      div_of_q    <= div_of_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign sf        = sf_q;
  assign of        = of_q;
  assign cf        = cf_q;
  assign dz        = dz_q;

  iter_alu_mdu #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_mdu (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (mdu_start),
    .abort_i    (flush),
`ifdef ITER_ALU_DIV_EN
    .is_div_i   (op[1]),
`endif
    .is_signed_i(~op[0]),
    .a_i        (a),
    .b_i        (b),
    .done_o     (mdu_done),
    .lo_o       (mdu_lo),
    .hi_o       (mdu_hi)
  );

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: stimulus pushes model results, a monitor pops and
// compares on every output handshake.
module tb_iter_alu;
  localparam int W = 32;
  localparam longint SMax = 64'sd2147483647;
  localparam longint SMin = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic [4:0]   shamt = '0;
  logic         flush = 1'b0;
  logic         out_valid, out_ready = 1'b1;
  logic [W-1:0] result, hi;
  logic         zero, sf, of, cf, dz, busy;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .shamt(shamt), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .hi(hi), .zero(zero), .sf(sf), .of(of),
    .cf(cf), .dz(dz), .busy(busy)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic z, s, o, c, d;
    int lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(logic [3:0] o, logic [31:0] x, logic [31:0] y, logic [4:0] s);
    exp_t e;
    longint sx, sy, t, q, r;
    logic [63:0] p, qv, rv;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.hi = '0; e.o = 0; e.c = 0; e.d = 0; e.lat = 1;
    p = '0;
    case (o)
      4'd0: begin
        t = sx + sy; e.res = x + y;
        e.c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        e.o = (t > SMax) || (t < SMin);
      end
      4'd4: begin
        t = sx - sy; e.res = x - y; e.c = (x < y);
        e.o = (t > SMax) || (t < SMin);
      end
      4'd1: e.res = x & y;
      4'd2: e.res = x | y;
      4'd3: e.res = x ^ y;
      4'd5: e.res = ~(x | y);
      4'd6: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd7: e.res = x;
      4'd8: e.res = y << s;
      4'd9: e.res = y >> s;
      4'd10: e.res = $signed(y) >>> s;
      4'd11: e.res = (sx < sy) ? 32'd1 : 32'd0;
      4'd12, 4'd13: begin
        if (o == 4'd12) begin t = sx * sy; p = t; end
        else p = {32'b0, x} * {32'b0, y};
        e.res = p[31:0]; e.hi = p[63:32]; e.lat = W + 1;
      end
      default: begin
`ifdef ITER_ALU_DIV_EN
        if (y == 0) begin
          e.res = '1; e.hi = x; e.d = 1;
        end else begin
          if (o == 4'd14) begin q = sx / sy; r = sx % sy; end
          else begin q = longint'({32'b0, x} / {32'b0, y}); r = longint'({32'b0, x} % {32'b0, y}); end
          qv = q; rv = r;
          e.res = qv[31:0]; e.hi = rv[31:0]; e.lat = W + 1;
          e.o = (o == 4'd14) && (q > SMax);
        end
`else
        e.d = 1;
`endif
      end
    endcase
    e.z = (o == 4'd12 || o == 4'd13) ? (p == 0) : (e.res == 0);
    e.s = e.res[31];
    return e;
  endfunction

  // Monitor: a handshake seen mid-cycle completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got result %h with empty scoreboard", result);
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.res);
        chk("hi", hi, mon_e.hi);
        chk("flags_zsocd", {zero, sf, of, cf, dz}, {mon_e.z, mon_e.s, mon_e.o, mon_e.c, mon_e.d});
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] s, input bit want, output exp_t e);
    bit acc;
    int guard, lat, bc;
    e = model(o, x, y, s);
    in_valid = 1; op = o; a = x; b = y; shamt = s;
    acc = 0; guard = 0;
    while (!acc && guard < 200) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; guard++;
    end
    in_valid = 0; a = $urandom; b = $urandom; op = 4'($urandom); shamt = 5'($urandom);
    if (!acc) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready never high for op %h", o);
      return;
    end
    if (!want) return;
    sbq.push_back(e);
    lat = 1; bc = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bc++;
      @(posedge clk); #1; lat++;
    end
    chk("latency", lat, e.lat);
    chk("busy_cycles", bc, e.lat - 1);
  endtask

  task automatic hold(input int n, input exp_t e);
    out_ready = 0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_result", result, e.res);
      chk("hold_hi", hi, e.hi);
    end
    out_ready = 1;
  endtask

  task automatic idle_no_output(input int n, input string name);
    bit seen = 0;
    repeat (n) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    chk(name, seen, 0);
  endtask

  exp_t e;
  logic [3:0] ro;
  logic [31:0] ra, rb;

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result_hi", {result, hi}, 0);
    chk("rst_flags", {zero, sf, of, cf, dz}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Signed overflow on ADD.
    issue(4'd0, 32'h7FFF_FFFF, 32'h1, 0, 1, e);
    chk("add_ovf_result", result, 32'h8000_0000);
    chk("add_ovf_flags_of_sf_cf", {of, sf, cf}, 3'b110);

    // Signed multiply.
    issue(4'd12, 32'hFFFF_FFFE, 32'h3, 0, 1, e);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", result, 32'hFFFF_FFFA);

`ifdef ITER_ALU_DIV_EN
    issue(4'd14, 32'hFFFF_FFF9, 32'h2, 0, 1, e);
    chk("div_q", result, 32'hFFFF_FFFD);
    chk("div_r", hi, 32'hFFFF_FFFF);
    issue(4'd15, 32'h5, 32'h0, 0, 1, e);
    chk("divu_dz", {dz, result, hi}, {1'b1, 32'hFFFF_FFFF, 32'h5});
    issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1, e);
    chk("div_min_ovf", {of, result, hi}, {1'b1, 32'h8000_0000, 32'h0});
`else
    issue(4'd14, 32'hFFFF_FFF9, 32'h2, 0, 1, e);
    chk("div_disabled", {dz, result, hi}, {1'b1, 64'h0});
`endif

    // Stall in HOLD, then back-to-back SUB.
    issue(4'd0, 32'h1, 32'h2, 0, 1, e);
    hold(5, e);
    issue(4'd4, 32'h3, 32'h5, 0, 1, e);
    chk("sub_result", result, 32'hFFFF_FFFE);
    chk("sub_cf", cf, 1);

    // Flush wins against a simultaneous request.
    @(posedge clk); #1;
    in_valid = 1; op = 4'd0; a = 32'd9; b = 32'd9; flush = 1;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    idle_no_output(4, "flush_drops_accept");

    // Flush in MUL cycle 10.
    issue(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0, e);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_state", {out_valid, busy, in_ready}, 3'b001);
    idle_no_output(40, "flush_no_output");
    issue(4'd0, 32'h1, 32'h1, 0, 1, e);
    chk("after_flush_add", result, 32'h2);

    // Reset in the iterative op's cycle 20.
`ifdef ITER_ALU_DIV_EN
    issue(4'd14, 32'h7654_3210, 32'h13, 0, 0, e);
`else
    issue(4'd13, 32'h7654_3210, 32'h13, 0, 0, e);
`endif
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    chk("async_rst_outputs", {out_valid, busy, result, hi}, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    idle_no_output(40, "rst_no_output");
    issue(4'd0, 32'h1, 32'h1, 0, 1, e);
    chk("after_rst_add", result, 32'h2);

    // Randomized mix with stalls and idle gaps.
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 6))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = ra & 32'hFF; rb = rb & 32'hF; end
        default: ;
      endcase
      issue(ro, ra, rb, 5'($urandom), 1, e);
      if ($urandom_range(0, 2) == 0) hold($urandom_range(1, 2), e);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
